// File: rtl/instr_queue.sv
// Instruction queue between fetch and dual-issue decode: circular buffer that
// accepts up to FETCH_NUM entries per cycle and presents the oldest ISSUE_NUM.
package instr_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FETCH_NUM = 2,
    parameter int unsigned ISSUE_NUM = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 stall,
    input  logic [$clog2(FETCH_NUM+1)-1:0]       push_num,
    input  fetch_entry_t [FETCH_NUM-1:0]         push_entry,
    output logic                                 full,
    input  logic [$clog2(ISSUE_NUM+1)-1:0]       pop_num,
    output fetch_entry_t [ISSUE_NUM-1:0]         out_entry,
    output logic [$clog2(DEPTH+1)-1:0]           count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PN_W  = $clog2(FETCH_NUM + 1);
    localparam int unsigned PP_W  = $clog2(ISSUE_NUM + 1);

    fetch_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;

    logic [PN_W-1:0]          w_push_acc;
    logic [PP_W-1:0]          w_pop_eff;

    // Full is judged on registered occupancy only; same-cycle pops do not free room.
    assign full  = (CNT_W'(DEPTH) - r_count) < CNT_W'(FETCH_NUM);
    assign count = r_count;

    // Push is all-or-nothing; pop is clamped so the issue stage may over-report.
    always_comb begin
        w_push_acc = '0;
        w_pop_eff  = '0;
        if (!full && !flush) begin
            w_push_acc = push_num;
        end
        if (!stall) begin
            if (CNT_W'(pop_num) < r_count) begin
                w_pop_eff = pop_num;
            end else begin
                w_pop_eff = PP_W'(r_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_eff);
            r_tail  <= r_tail + PTR_W'(w_push_acc);
            r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_eff);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < FETCH_NUM; k++) begin
                if (PN_W'(k) < w_push_acc) begin
                    r_mem[r_tail + PTR_W'(k)] <= push_entry[k];
                end
            end
        end
    end

    always_comb begin
        out_entry = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (CNT_W'(i) < r_count) begin
                out_entry[i]       = r_mem[r_head + PTR_W'(i)];
                out_entry[i].valid = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: hand-computed expectations for push/pop,
// clamping, full, flush, stall, reset and pointer wrap.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned FETCH_NUM = 2;
    localparam int unsigned ISSUE_NUM = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic                        stall;
    logic [1:0]                  push_num;
    fetch_entry_t [FETCH_NUM-1:0] push_entry;
    logic                        full;
    logic [1:0]                  pop_num;
    fetch_entry_t [ISSUE_NUM-1:0] out_entry;
    logic [4:0]                  count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_queue #(.DEPTH(DEPTH), .FETCH_NUM(FETCH_NUM), .ISSUE_NUM(ISSUE_NUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .push_num  (push_num),
        .push_entry(push_entry),
        .full      (full),
        .pop_num   (pop_num),
        .out_entry (out_entry),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (push_num <= 2'(FETCH_NUM)) else $error("push_num above FETCH_NUM");
    end

    function automatic fetch_entry_t mk(input logic [31:0] v);
        fetch_entry_t e;
        e.valid = 1'b1;
        e.pc    = v << 2;
        e.instr = v;
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input int pn, input logic [31:0] a, input logic [31:0] b,
                        input int pp, input logic st, input logic fl);
        push_num      = 2'(pn);
        push_entry[0] = (pn > 0) ? mk(a) : '0;
        push_entry[1] = (pn > 1) ? mk(b) : '0;
        pop_num       = 2'(pp);
        stall         = st;
        flush         = fl;
        @(posedge clk);
        #1;
        push_num   = '0;
        push_entry = '0;
        pop_num    = '0;
        stall      = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b);
        check_eq({tag, "_out0"}, 96'(out_entry[0]), 96'(mk(a)));
        check_eq({tag, "_out1"}, 96'(out_entry[1]), 96'(mk(b)));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        push_num = '0; pop_num = '0; push_entry = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_count", 96'(count), 96'(0));
        check_eq("rst_full", 96'(full), 96'(0));
        check_eq("rst_out0", 96'(out_entry[0]), 96'(0));
        check_eq("rst_out1", 96'(out_entry[1]), 96'(0));

        // Basic push, partial pop, then over-reported pop clamped at empty.
        step(2, 32'hA, 32'hB, 0, 0, 0);
        chk_out("push_ab", 32'hA, 32'hB);
        check_eq("push_ab_count", 96'(count), 96'(2));
        check_eq("push_ab_full", 96'(full), 96'(0));
        step(0, 0, 0, 1, 0, 0);
        check_eq("pop1_out0", 96'(out_entry[0]), 96'(mk(32'hB)));
        check_eq("pop1_out1", 96'(out_entry[1]), 96'(0));
        check_eq("pop1_count", 96'(count), 96'(1));
        step(0, 0, 0, 2, 0, 0);
        check_eq("clamp_count", 96'(count), 96'(0));
        check_eq("clamp_out0", 96'(out_entry[0]), 96'(0));

        // Fill to 15 entries: full asserts and pushes are dropped, even alongside a pop.
        for (int i = 0; i < 7; i++) step(2, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 0, 0, 0);
        step(1, 32'h10E, 0, 0, 0, 0);
        check_eq("fill_count", 96'(count), 96'(15));
        check_eq("fill_full", 96'(full), 96'(1));
        chk_out("fill", 32'h100, 32'h101);
        step(2, 32'hDEAD, 32'hBEEF, 0, 0, 0);
        check_eq("full_push_count", 96'(count), 96'(15));
        step(2, 32'hDEAD, 32'hBEEF, 2, 0, 0);
        check_eq("full_pushpop_count", 96'(count), 96'(13));
        check_eq("full_pushpop_full", 96'(full), 96'(0));
        chk_out("full_pushpop", 32'h102, 32'h103);

        // Steady push 2 / pop 2 with sequential values across two pointer wraps.
        step(0, 0, 0, 0, 0, 1);
        check_eq("flush1_count", 96'(count), 96'(0));
        step(2, 32'd0, 32'd1, 0, 0, 0);
        chk_out("steady_pre", 32'd0, 32'd1);
        for (int i = 1; i < 40; i++) begin
            step(2, 32'(2*i), 32'(2*i+1), 2, 0, 0);
            chk_out($sformatf("steady%0d", i), 32'(2*i), 32'(2*i+1));
            check_eq($sformatf("steady%0d_count", i), 96'(count), 96'(2));
        end

        // Flush wins over a simultaneous push and pop; the next push is accepted.
        step(2, 32'd80, 32'd81, 0, 0, 0);
        step(2, 32'd82, 32'd83, 0, 0, 0);
        check_eq("pre_flush_count", 96'(count), 96'(6));
        step(2, 32'hE0, 32'hE1, 2, 0, 1);
        check_eq("flush_count", 96'(count), 96'(0));
        check_eq("flush_v0", 96'(out_entry[0].valid), 96'(0));
        check_eq("flush_v1", 96'(out_entry[1].valid), 96'(0));
        step(2, 32'hC0, 32'hC1, 0, 0, 0);
        chk_out("post_flush", 32'hC0, 32'hC1);
        check_eq("post_flush_count", 96'(count), 96'(2));

        // Stall blocks popping but not pushing.
        step(2, 32'hC2, 32'hC3, 0, 0, 0);
        check_eq("pre_stall_count", 96'(count), 96'(4));
        step(0, 0, 0, 2, 1, 0);
        check_eq("stall_count", 96'(count), 96'(4));
        chk_out("stall", 32'hC0, 32'hC1);
        step(2, 32'hC4, 32'hC5, 2, 1, 0);
        check_eq("stall_push_count", 96'(count), 96'(6));
        chk_out("stall_push", 32'hC0, 32'hC1);

        // Walk head to DEPTH-1 so a two-slot read straddles the wrap.
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h300, 0, 0, 0, 0);
        for (int i = 1; i < 15; i++) step(1, 32'h300 + 32'(i), 0, 1, 0, 0);
        check_eq("walk_count", 96'(count), 96'(1));
        check_eq("walk_out0", 96'(out_entry[0]), 96'(mk(32'h30E)));
        step(2, 32'h3F0, 32'h3F1, 1, 0, 0);
        check_eq("wrap_count", 96'(count), 96'(2));
        chk_out("wrap", 32'h3F0, 32'h3F1);
        step(2, 32'h3F2, 32'h3F3, 2, 0, 0);
        chk_out("wrap_after", 32'h3F2, 32'h3F3);

        // Reset asserted mid-operation clears state and holds it.
        rst = 1'b1;
        step(2, 32'h400, 32'h401, 0, 0, 0);
        check_eq("midrst_count", 96'(count), 96'(0));
        step(2, 32'h402, 32'h403, 0, 0, 0);
        check_eq("midrst_hold_count", 96'(count), 96'(0));
        check_eq("midrst_out0", 96'(out_entry[0]), 96'(0));
        rst = 1'b0;
        step(2, 32'h404, 32'h405, 0, 0, 0);
        chk_out("post_rst", 32'h404, 32'h405);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction queue between the fetch stage and the dual-issue decode/issue stage. Accepts up to `FETCH_NUM` fetched instructions per cycle and presents the oldest `ISSUE_NUM` entries, in program order, to decode/issue. Removes 0..`ISSUE_NUM` entries per cycle according to the issue count returned by issue. Absorbs fetch/issue rate mismatch and is cleared on pipeline flush.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, at least 4.
- `FETCH_NUM`, 2, maximum entries pushed per cycle.
- `ISSUE_NUM`, 2, entries presented and maximum entries popped per cycle; equals `` `ISSUE_NUM ``.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  discard all entries (mispredict or exception).
- `stall`  in  1  pipeline stall; when 1, no entries are popped.
- `push_num`  in  $clog2(FETCH_NUM+1)  number of valid entries in `push_entry`; slots 0..push_num-1 are used, in order.
- `push_entry`  in  FETCH_NUM x fetch_entry_t  fetched instructions; slot 0 is oldest.
- `full`  out  1  fewer than `FETCH_NUM` free slots; the whole push is ignored.
- `pop_num`  in  $clog2(ISSUE_NUM+1)  issue count from the issue stage.
- `out_entry`  out  ISSUE_NUM x fetch_entry_t  oldest entries; `out_entry[i].valid` = 1 only if slot i is occupied, otherwise the whole entry is zero.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer: storage `DEPTH` x fetch_entry_t, `head` (oldest) and `tail` (next write) pointers of width $clog2(DEPTH), plus a `count` register of width $clog2(DEPTH+1). Pointers wrap modulo `DEPTH`.
- `out_entry[i]` = storage[(head+i) mod DEPTH] when i < count, else all-zero. This is a combinational read of registered state.
- `full` = (DEPTH - count) < FETCH_NUM. It is computed from the registered count and ignores same-cycle pops.
- Push: if !full and !flush, write `push_entry[k]` to storage[(tail+k) mod DEPTH] for k < push_num. Then tail += push_num.
- Effective pop: `eff_pop` = stall ? 0 : min(pop_num, count). Then head += eff_pop.
  - Clamping is mandatory: the issue stage reports 1 or 2 even when entries are invalid.
- count_next = count + accepted_push - eff_pop. Simultaneous push and pop both take effect in the same cycle.
- Flush: head = tail = count = 0. Push and pop in the same cycle are discarded. Storage contents need not be cleared.
- Priority: rst > flush > push/pop.
- Push with `push_num` > FETCH_NUM is illegal; behaviour is undefined, and the bench asserts it never occurs.
- Pop never reads past tail, and push never overwrites unpopped entries. Both are guaranteed by the clamp and by `full`.

## Timing
- Reset values: head = tail = count = 0, `full` = 0, `out_entry` all-zero (valid = 0), `count` = 0.
- Push-to-output latency: 1 cycle. An entry written at edge N appears on `out_entry` after edge N when it is at the head.
- Pop takes effect at the edge. The next entries appear in the following cycle.
- Empty plus push in the same cycle: `out_entry` stays invalid that cycle and the entry appears next cycle. There is no bypass.
- `flush` in cycle N: after edge N, count = 0 and `out_entry` is invalid. A fetch push in cycle N+1 is accepted.
- `rst` held mid-operation: state is cleared at the first edge with rst = 1 and held until release.
- Wrap-around: head or tail at DEPTH-1 advancing by 2 lands on 1. A two-slot read straddling the wrap (head = DEPTH-1) returns storage[DEPTH-1], then storage[0].

## Test plan
- Reset, then push_num = 2 of instrs A, B at cycle 1 -> cycle 2: out_entry = {A, B}, valid = 11, count = 2, full = 0.
- Push A, B, then pop_num = 1 -> next cycle out_entry = {B, invalid}, count = 1. Then pop_num = 2 with count = 1 -> count = 0, not wrapping negative.
- Fill to count = 15 with DEPTH = 16 -> full = 1. A push of 2 is ignored and count stays 15. Pop 2 with a simultaneous push in the same cycle -> the push is still ignored and count = 13.
- Steady push 2 / pop 2 for 40 cycles with sequential instr values 0..79 -> outputs appear strictly in order across pointer wrap, with count constant at its initial value.
- count = 6, flush = 1 together with push 2 and pop 2 -> next cycle count = 0 and out_entry valid = 00. A push of X, Y the following cycle -> out_entry = {X, Y}.
- stall = 1 with pop_num = 2, count = 4 -> count unchanged and out_entry unchanged. A push of 2 in the same cycle -> count = 6.
